// File: rtl/seq_mult_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_mult_hs                                                       |
// | Desc   : N-cycle shift-add multiplier, start/busy/done, signed or unsigned |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module seq_mult_hs #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW     = $clog2(N) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a;
  logic           r_signed;
  logic [2*N:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;

  logic [N-1:0]   w_addend;
  logic [N:0]     w_hi_ext;
  logic [N:0]     w_add_ext;
  logic [N:0]     w_sum;
  logic           w_last;
  logic           w_top;
  logic           w_accept;
  logic [2*N:0]   w_acc_next;

  // In signed mode acc[2N] always equals acc[2N-1], so it doubles as the sign extension of hi.
  always_comb begin
    w_addend   = r_acc[0] ? r_a : '0;
    w_hi_ext   = r_signed ? r_acc[2*N:N] : {1'b0, r_acc[2*N-1:N]};
    w_add_ext  = r_signed ? {w_addend[N-1], w_addend} : {1'b0, w_addend};
    w_last     = (r_cnt == C_LAST);
    w_sum      = (r_signed && w_last) ? (w_hi_ext - w_add_ext) : (w_hi_ext + w_add_ext);
    w_top      = r_signed & w_sum[N];
    w_acc_next = {w_top, w_sum, r_acc[N-1:1]};
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_signed  <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a      <= multiplicand;
        r_signed <= is_signed;
        r_acc    <= {{(N+1){1'b0}}, multiplier};
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_product <= w_acc_next[2*N-1:0];
      end
    end
  end

  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_seq_mult_hs                                                    |
// | Desc   : scoreboard bench for seq_mult_hs at N=8 and N=16                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_seq_mult_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q8[$];
  logic [31:0] q16[$];

  always #5 clk = ~clk;

  seq_mult_hs #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  seq_mult_hs #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected product whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb8_unexpected_done: got product %0h expected no done", product8);
      end else begin
        check("sb8_product", product8, q8.pop_front());
      end
      check("sb8_busy_in_done", busy8, 1'b0);
    end
    if (done16) begin
      if (q16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb16_unexpected_done: got product %0h expected no done", product16);
      end else begin
        check("sb16_product", product16, q16.pop_front());
      end
    end
  end

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int nb;
    @(posedge clk); #1;
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    nb = 0;
    while (busy8 && nb < 40) begin
      nb++;
      @(posedge clk); #1;
    end
    check("busy8_cycles", nb, 8);
    check("done8_high", done8, 1'b1);
    @(posedge clk); #1;
    check("done8_one_cycle", done8, 1'b0);
  endtask

  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    int nb;
    @(posedge clk); #1;
    start16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
    q16.push_back(exp);
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    nb = 0;
    while (busy16 && nb < 60) begin
      nb++;
      @(posedge clk); #1;
    end
    check("busy16_cycles", nb, 16);
    check("done16_high", done16, 1'b1);
    @(posedge clk); #1;
    check("done16_one_cycle", done16, 1'b0);
  endtask

  initial begin
    int k;
    logic [15:0] ra, rb;
    logic        rs;
    logic signed [31:0] sp;
    logic [31:0] up;

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    check("reset_product", product8, 16'h0000);
    check("reset_product16", product16, 32'h0);
    rst = 1'b0;

    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8(1'b1, 8'hFD, 8'h05, 16'hFFF1);
    op8(1'b0, 8'hFD, 8'h05, 16'h04F1);
    op8(1'b1, 8'h80, 8'h80, 16'h4000);
    op8(1'b1, 8'h80, 8'h7F, 16'hC080);
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001);

    // start held through a run with changing operands, then a back-to-back accept in DONE
    @(posedge clk); #1;
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd10; b8 = 8'd11;
    q8.push_back(16'h006E);
    @(posedge clk); #1;
    k = 0;
    while (busy8 && k < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      k++;
      @(posedge clk); #1;
    end
    check("ignore_busy_cycles", k, 8);
    check("ignore_done_high", done8, 1'b1);
    a8 = 8'd12; b8 = 8'd11; sgn8 = 1'b0;
    q8.push_back(16'h0084);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_busy", busy8, 1'b1);
    check("b2b_product_held", product8, 16'h006E);
    k = 1;
    while (!done8 && k < 40) begin
      k++;
      @(posedge clk); #1;
    end
    check("b2b_done_spacing", k, 9);
    @(posedge clk); #1;

    // reset three cycles into a run
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'h55; b8 = 8'h33;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_product", product8, 16'h0000);
    op8(1'b0, 8'd7, 8'd6, 16'h002A);

    op16(1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    op16(1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    op16(1'b1, 16'h8000, 16'hFFFF, 32'h0000_8000);
    op16(1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
    op16(1'b1, 16'h1234, 16'hFFFE, 32'hFFFF_DB98);
    op16(1'b0, 16'h1234, 16'h0010, 32'h0001_2340);
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      sp = $signed(ra) * $signed(rb);
      up = ra * rb;
      op16(rs, ra, rb, rs ? 32'(sp) : up);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb8_drained", q8.size(), 0);
    check("sb16_drained", q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
